// File: rtl/screen_sequencer.sv
// Screen sequencer: menu -> arm -> play -> end flow with a per-second round timer and frame-aligned screen switching.
// Optional pause support is enabled by defining SCREEN_SEQUENCER_PAUSE_EN.
`timescale 1ns/1ps
module screen_sequencer #(
    parameter int GAME_SECONDS   = 60,
    parameter int FRAMES_PER_SEC = 60,
    parameter int END_HOLD_SEC   = 3
) (
    input  logic        clk40,
    input  logic        rst,
    input  logic        vsync,
    input  logic        start,
    input  logic        restart,
    input  logic        pause,
    input  logic [11:0] rgb_menu,
    input  logic [11:0] rgb_game,
    input  logic [11:0] rgb_end,
    output logic [11:0] rgb_out,
    output logic [1:0]  screen_sel,
    output logic        game_rst,
    output logic        game_en,
    output logic [7:0]  time_left
);

    localparam logic [7:0] ROUND_SECS = 8'(GAME_SECONDS);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(END_HOLD_SEC - 1);

`ifdef SCREEN_SEQUENCER_PAUSE_EN
    typedef enum logic [2:0] {ST_MENU, ST_ARM, ST_PLAY, ST_END, ST_PAUSE} state_t;
`else
    typedef enum logic [1:0] {ST_MENU, ST_ARM, ST_PLAY, ST_END} state_t;
`endif

    state_t      state_q, state_d;
    logic        vsync_q, start_q, restart_q, pause_q;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  time_left_q, time_left_d;
    logic [1:0]  screen_sel_q, screen_sel_d;
    logic [11:0] rgb_out_q, rgb_out_d;
    logic        game_rst_q, game_rst_d;
    logic        game_en_q, game_en_d;

    logic frame_tick, start_edge, restart_edge, pause_edge;

    assign frame_tick   = vsync & ~vsync_q;
    assign start_edge   = start & ~start_q;
    assign restart_edge = restart & ~restart_q;
    assign pause_edge   = pause & ~pause_q;

`ifndef SCREEN_SEQUENCER_PAUSE_EN
    logic unused_pause_edge;
    assign unused_pause_edge = pause_edge;
`endif

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        time_left_d  = time_left_q;
        screen_sel_d = screen_sel_q;
        game_rst_d   = 1'b0;

        case (state_q)
            ST_MENU: begin
                if (start_edge) begin
                    state_d     = ST_ARM;
                    game_rst_d  = 1'b1;
                    time_left_d = ROUND_SECS;
                end
            end
            ST_ARM: begin
                if (frame_tick) begin
                    state_d     = ST_PLAY;
                    frame_cnt_d = 8'd0;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = 8'd0;
                        if (time_left_q > 8'd1) begin
                            time_left_d = time_left_q - 8'd1;
                        end else begin
                            time_left_d = 8'd0;
                            hold_cnt_d  = 8'd0;
                            state_d     = ST_END;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
                // A tick landing with the pause click is still counted, so no frame is lost.
                if (pause_edge && state_d == ST_PLAY) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
            ST_END: begin
                if (restart_edge) begin
                    state_d     = ST_ARM;
                    game_rst_d  = 1'b1;
                    time_left_d = ROUND_SECS;
                end else if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = 8'd0;
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d = ST_MENU;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
            ST_PAUSE: begin
                if (pause_edge) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: state_d = ST_MENU;
        endcase

        game_en_d = (state_d == ST_PLAY);

        // Screen changes only at frame boundaries so a switch never tears a frame.
        if (frame_tick) begin
            case (state_q)
                ST_MENU: screen_sel_d = 2'd0;
                ST_END:  screen_sel_d = 2'd2;
                default: screen_sel_d = 2'd1;
            endcase
        end

        case (screen_sel_q)
            2'd0:    rgb_out_d = rgb_menu;
            2'd1:    rgb_out_d = rgb_game;
            2'd2:    rgb_out_d = rgb_end;
            default: rgb_out_d = 12'h000;
        endcase
    end

    always_ff @(posedge clk40 or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_MENU;
            vsync_q      <= 1'b0;
            start_q      <= 1'b0;
            restart_q    <= 1'b0;
            pause_q      <= 1'b0;
            frame_cnt_q  <= 8'd0;
            hold_cnt_q   <= 8'd0;
            time_left_q  <= 8'd0;
            screen_sel_q <= 2'd0;
            rgb_out_q    <= 12'h000;
            game_rst_q   <= 1'b0;
            game_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            start_q      <= start;
            restart_q    <= restart;
            pause_q      <= pause;
            frame_cnt_q  <= frame_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            time_left_q  <= time_left_d;
            screen_sel_q <= screen_sel_d;
            rgb_out_q    <= rgb_out_d;
            game_rst_q   <= game_rst_d;
            game_en_q    <= game_en_d;
        end
    end

    assign rgb_out    = rgb_out_q;
    assign screen_sel = screen_sel_q;
    assign game_rst   = game_rst_q;
    assign game_en    = game_en_q;
    assign time_left  = time_left_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed self-checking bench for screen_sequencer (GAME_SECONDS=3, FRAMES_PER_SEC=2, END_HOLD_SEC=1).
// Define SCREEN_SEQUENCER_PAUSE_EN to exercise the pause flow.
`timescale 1ns/1ps
module tb_screen_sequencer;

    logic        clk40 = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b0;
    logic        start = 1'b0;
    logic        restart = 1'b0;
    logic        pause = 1'b0;
    logic [11:0] rgb_menu = 12'hA11;
    logic [11:0] rgb_game = 12'hB22;
    logic [11:0] rgb_end  = 12'hC33;
    logic [11:0] rgb_out;
    logic [1:0]  screen_sel;
    logic        game_rst;
    logic        game_en;
    logic [7:0]  time_left;

    int n_checks = 0;
    int n_fail   = 0;
    int rst_pulses;

    always #10 clk40 = ~clk40;

    screen_sequencer #(
        .GAME_SECONDS(3),
        .FRAMES_PER_SEC(2),
        .END_HOLD_SEC(1)
    ) dut (
        .clk40(clk40),
        .rst(rst),
        .vsync(vsync),
        .start(start),
        .restart(restart),
        .pause(pause),
        .rgb_menu(rgb_menu),
        .rgb_game(rgb_game),
        .rgb_end(rgb_end),
        .rgb_out(rgb_out),
        .screen_sel(screen_sel),
        .game_rst(game_rst),
        .game_en(game_en),
        .time_left(time_left)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk40);
    endtask

    task automatic frameTick();
        @(negedge clk40) vsync = 1'b1;
        @(negedge clk40) vsync = 1'b0;
    endtask

    task automatic pressStart();
        @(negedge clk40) start = 1'b1;
        @(negedge clk40) start = 1'b0;
    endtask

    task automatic pressRestart();
        @(negedge clk40) restart = 1'b1;
        @(negedge clk40) restart = 1'b0;
    endtask

    task automatic pressPause();
        @(negedge clk40) pause = 1'b1;
        @(negedge clk40) pause = 1'b0;
    endtask

    initial begin
        int exp_tl[6] = '{3, 2, 2, 1, 1, 0};

        idle(3);
        checkOutput("rst_rgb_out", rgb_out, 12'h000);
        checkOutput("rst_screen_sel", screen_sel, 2'd0);
        checkOutput("rst_game_en", game_en, 1'b0);
        checkOutput("rst_time_left", time_left, 8'd0);
        @(negedge clk40) rst = 1'b1;
        idle(2);
        checkOutput("idle_screen_sel", screen_sel, 2'd0);
        checkOutput("idle_game_en", game_en, 1'b0);
        checkOutput("idle_time_left", time_left, 8'd0);
        checkOutput("idle_rgb_menu", rgb_out, 12'hA11);

        pressStart();
        checkOutput("start_game_rst", game_rst, 1'b1);
        checkOutput("start_time_left", time_left, 8'd3);
        checkOutput("start_screen_sel", screen_sel, 2'd0);
        checkOutput("start_game_en", game_en, 1'b0);
        idle(1);
        checkOutput("start_game_rst_one_cycle", game_rst, 1'b0);

        frameTick();
        checkOutput("arm_to_play_game_en", game_en, 1'b1);
        checkOutput("arm_to_play_screen_sel", screen_sel, 2'd1);
        checkOutput("rgb_latency_old", rgb_out, 12'hA11);
        idle(1);
        checkOutput("rgb_game_selected", rgb_out, 12'hB22);

        for (int i = 0; i < 6; i++) begin
            frameTick();
            checkOutput($sformatf("play_tl_%0d", i), time_left, exp_tl[i]);
        end
        checkOutput("end_game_en", game_en, 1'b0);
        checkOutput("end_screen_sel_hold", screen_sel, 2'd1);

        pressStart();
        checkOutput("start_ignored_in_end", game_rst, 1'b0);
        frameTick();
        checkOutput("end_screen_sel", screen_sel, 2'd2);
        idle(1);
        checkOutput("rgb_end_selected", rgb_out, 12'hC33);
        frameTick();
        checkOutput("hold_expiry_screen_sel", screen_sel, 2'd2);
        checkOutput("hold_expiry_time_left", time_left, 8'd0);
        pressRestart();
        checkOutput("restart_ignored_in_menu", game_rst, 1'b0);
        frameTick();
        checkOutput("menu_screen_sel", screen_sel, 2'd0);
        checkOutput("menu_game_en", game_en, 1'b0);

        pressStart();
        checkOutput("round2_game_rst", game_rst, 1'b1);
        frameTick();
        repeat (6) frameTick();
        checkOutput("round2_time_left", time_left, 8'd0);
        checkOutput("round2_game_en", game_en, 1'b0);
        frameTick();
        checkOutput("round2_end_screen", screen_sel, 2'd2);
        @(negedge clk40) begin
            vsync   = 1'b1;
            restart = 1'b1;
        end
        @(negedge clk40) begin
            vsync   = 1'b0;
            restart = 1'b0;
        end
        checkOutput("restart_on_expiry_game_rst", game_rst, 1'b1);
        checkOutput("restart_on_expiry_time_left", time_left, 8'd3);
        checkOutput("restart_on_expiry_screen_sel", screen_sel, 2'd2);
        idle(1);
        checkOutput("restart_game_rst_one_cycle", game_rst, 1'b0);
        frameTick();
        checkOutput("restart_play_game_en", game_en, 1'b1);
        checkOutput("restart_play_screen_sel", screen_sel, 2'd1);

        @(negedge clk40) rst = 1'b0;
        #1;
        checkOutput("midplay_rst_screen_sel", screen_sel, 2'd0);
        checkOutput("midplay_rst_game_en", game_en, 1'b0);
        checkOutput("midplay_rst_time_left", time_left, 8'd0);
        checkOutput("midplay_rst_rgb_out", rgb_out, 12'h000);
        @(negedge clk40) rst = 1'b1;
        idle(2);
        frameTick();
        frameTick();
        checkOutput("post_rst_screen_sel", screen_sel, 2'd0);
        checkOutput("post_rst_game_en", game_en, 1'b0);
        checkOutput("post_rst_time_left", time_left, 8'd0);

        rst_pulses = 0;
        @(negedge clk40) start = 1'b1;
        repeat (100) begin
            @(negedge clk40);
            if (game_rst) rst_pulses++;
        end
        start = 1'b0;
        checkOutput("held_start_pulses", rst_pulses, 1);
        checkOutput("held_start_time_left", time_left, 8'd3);

        frameTick();
        frameTick();
        frameTick();
        checkOutput("pre_pause_time_left", time_left, 8'd2);
        pressPause();
`ifdef SCREEN_SEQUENCER_PAUSE_EN
        checkOutput("pause_game_en", game_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            frameTick();
            checkOutput($sformatf("paused_tl_%0d", i), time_left, 8'd2);
            checkOutput($sformatf("paused_game_en_%0d", i), game_en, 1'b0);
        end
        checkOutput("paused_screen_sel", screen_sel, 2'd1);
        pressPause();
        checkOutput("resume_game_en", game_en, 1'b1);
        frameTick();
        checkOutput("resume_tl_a", time_left, 8'd2);
        frameTick();
        checkOutput("resume_tl_b", time_left, 8'd1);
`else
        checkOutput("pause_ignored_game_en", game_en, 1'b1);
        frameTick();
        checkOutput("nopause_tl_a", time_left, 8'd2);
        frameTick();
        checkOutput("nopause_tl_b", time_left, 8'd1);
        frameTick();
        frameTick();
        checkOutput("nopause_tl_c", time_left, 8'd0);
        checkOutput("nopause_end_game_en", game_en, 1'b0);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
